// File: rtl/marker_overlay_ctrl.sv
// Marker overlay sequencer: per-slot pending updates commit at frame start; per-pixel priority hit.
// Optional macro MARKER_BLINK_EN adds a frame-counted blink phase that hides blink-tagged markers.
module marker_overlay_ctrl #(
  parameter int unsigned NUM          = 4,
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned HEIGHT       = 8,
  parameter int unsigned BLINK_FRAMES = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [10:0]         hcount,
  input  logic [9:0]          vcount,
  input  logic                frame_start,
  input  logic [NUM-1:0]      upd_valid,
  output logic [NUM-1:0]      upd_ready,
  input  logic [11*NUM-1:0]   upd_x,
  input  logic [10*NUM-1:0]   upd_y,
  input  logic [8*NUM-1:0]    upd_color,
  input  logic [NUM-1:0]      upd_en,
  input  logic [NUM-1:0]      upd_blink,
  output logic [NUM-1:0]      commit_mask,
  output logic [7:0]          pixel
);

  typedef enum logic {StEmpty, StPending} slot_state_e;

  slot_state_e state_q [NUM];
  slot_state_e state_d [NUM];

  logic [NUM-1:0][10:0] pend_x_q, act_x_q;
  logic [NUM-1:0][9:0]  pend_y_q, act_y_q;
  logic [NUM-1:0][7:0]  pend_color_q, act_color_q;
  logic [NUM-1:0]       pend_en_q, act_en_q;
  logic [NUM-1:0]       commit_mask_q;
  logic [7:0]           pixel_q, pixel_d;
  logic [NUM-1:0]       hit, vis;

  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      state_d[i]   = state_q[i];
      upd_ready[i] = (state_q[i] == StEmpty);
      unique case (state_q[i])
        StEmpty:   if (upd_valid[i]) state_d[i] = StPending;
        StPending: if (frame_start)  state_d[i] = StEmpty;
        default:   state_d[i] = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM; i++) state_q[i] <= StEmpty;
      pend_x_q      <= '0;
      pend_y_q      <= '0;
      pend_color_q  <= '0;
      pend_en_q     <= '0;
      act_x_q       <= '0;
      act_y_q       <= '0;
      act_color_q   <= '0;
      act_en_q      <= '0;
      commit_mask_q <= '0;
      pixel_q       <= '0;
    end else begin
      for (int i = 0; i < NUM; i++) begin
        state_q[i] <= state_d[i];
        if (upd_valid[i] && upd_ready[i]) begin
          pend_x_q[i]     <= upd_x[11*i +: 11];
          pend_y_q[i]     <= upd_y[10*i +: 10];
          pend_color_q[i] <= upd_color[8*i +: 8];
          pend_en_q[i]    <= upd_en[i];
        end
        if (frame_start) begin
          commit_mask_q[i] <= (state_q[i] == StPending);
          if (state_q[i] == StPending) begin
            act_x_q[i]     <= pend_x_q[i];
            act_y_q[i]     <= pend_y_q[i];
            act_color_q[i] <= pend_color_q[i];
            act_en_q[i]    <= pend_en_q[i];
          end
        end
      end
      pixel_q <= pixel_d;
    end
  end

`ifdef MARKER_BLINK_EN
  localparam int unsigned CntW = (BLINK_FRAMES < 2) ? 1 : $clog2(BLINK_FRAMES + 1);

  logic [CntW-1:0] blink_cnt_q;
  logic            blink_phase_q;
  logic [NUM-1:0]  pend_blink_q, act_blink_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pend_blink_q  <= '0;
      act_blink_q   <= '0;
    end else begin
      if (frame_start) begin
        if (blink_cnt_q == CntW'(BLINK_FRAMES - 1)) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end
      for (int i = 0; i < NUM; i++) begin
        if (upd_valid[i] && upd_ready[i]) pend_blink_q[i] <= upd_blink[i];
        if (frame_start && state_q[i] == StPending) act_blink_q[i] <= pend_blink_q[i];
      end
    end
  end

  assign vis = ~(act_blink_q & {NUM{blink_phase_q}});
`else
  logic unused_blink;
  assign unused_blink = ^upd_blink;
  assign vis          = '1;
`endif

  // End coordinates carry one extra bit so markers at the raster edge clip instead of wrapping.
  for (genvar g = 0; g < NUM; g++) begin : g_hit
    logic [11:0] x_end;
    logic [10:0] y_end;
    assign x_end  = {1'b0, act_x_q[g]} + 12'(WIDTH);
    assign y_end  = {1'b0, act_y_q[g]} + 11'(HEIGHT);
    assign hit[g] = act_en_q[g] & vis[g]
                  & (hcount >= act_x_q[g]) & ({1'b0, hcount} < x_end)
                  & (vcount >= act_y_q[g]) & ({1'b0, vcount} < y_end);
  end

  always_comb begin
    pixel_d = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (hit[i]) pixel_d = act_color_q[i];
    end
  end

  assign commit_mask = commit_mask_q;
  assign pixel       = pixel_q;

endmodule

// File: tb/tb_marker_overlay_ctrl.sv
// Scoreboard bench for marker_overlay_ctrl: a frame-level reference model predicts pixel,
// ready and commit state; a negedge monitor pops expectations and compares.
module tb_marker_overlay_ctrl;
  localparam int unsigned NUM          = 4;
  localparam int unsigned WIDTH        = 8;
  localparam int unsigned HEIGHT       = 8;
  localparam int unsigned BLINK_FRAMES = 15;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [10:0]       hcount = '0;
  logic [9:0]        vcount = '0;
  logic              frame_start = 1'b0;
  logic [NUM-1:0]    upd_valid = '0;
  logic [NUM-1:0]    upd_ready;
  logic [11*NUM-1:0] upd_x = '0;
  logic [10*NUM-1:0] upd_y = '0;
  logic [8*NUM-1:0]  upd_color = '0;
  logic [NUM-1:0]    upd_en = '0;
  logic [NUM-1:0]    upd_blink = '0;
  logic [NUM-1:0]    commit_mask;
  logic [7:0]        pixel;

  always #5 clk = ~clk;

  marker_overlay_ctrl #(
    .NUM(NUM), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .frame_start(frame_start),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_x(upd_x), .upd_y(upd_y),
    .upd_color(upd_color), .upd_en(upd_en), .upd_blink(upd_blink),
    .commit_mask(commit_mask), .pixel(pixel)
  );

  int errors = 0;
  int checks = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: requests held per slot, an active list, and a frame counter for blink.
  bit  m_pend [NUM];
  int  m_px [NUM], m_py [NUM], m_pc [NUM];
  bit  m_pen [NUM], m_pbl [NUM];
  int  m_ax [NUM], m_ay [NUM], m_ac [NUM];
  bit  m_aen [NUM], m_abl [NUM];
  bit  m_cm [NUM];
  int  m_frames;
  bit  m_phase;
  logic [7:0] exp_q[$];

  function automatic int model_pixel(int h, int v);
    for (int i = 0; i < NUM; i++) begin
      bit shown;
      shown = m_aen[i];
`ifdef MARKER_BLINK_EN
      if (m_abl[i] && m_phase) shown = 1'b0;
`endif
      if (shown && h >= m_ax[i] && h < m_ax[i] + WIDTH && v >= m_ay[i] && v < m_ay[i] + HEIGHT)
        return m_ac[i];
    end
    return 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM; i++) begin
        m_pend[i] = 0; m_aen[i] = 0; m_abl[i] = 0; m_cm[i] = 0;
        m_ax[i] = 0; m_ay[i] = 0; m_ac[i] = 0;
      end
      m_frames = 0;
      m_phase  = 0;
      exp_q.delete();
    end else begin
      exp_q.push_back(8'(model_pixel(int'(hcount), int'(vcount))));
      for (int i = 0; i < NUM; i++) begin
        if (m_pend[i]) begin
          if (frame_start) begin
            m_ax[i] = m_px[i]; m_ay[i] = m_py[i]; m_ac[i] = m_pc[i];
            m_aen[i] = m_pen[i]; m_abl[i] = m_pbl[i];
            m_cm[i] = 1; m_pend[i] = 0;
          end
        end else begin
          if (frame_start) m_cm[i] = 0;
          if (upd_valid[i]) begin
            m_pend[i] = 1;
            m_px[i] = int'(upd_x[11*i +: 11]);
            m_py[i] = int'(upd_y[10*i +: 10]);
            m_pc[i] = int'(upd_color[8*i +: 8]);
            m_pen[i] = upd_en[i];
            m_pbl[i] = upd_blink[i];
          end
        end
      end
      if (frame_start) begin
        m_frames++;
        if (m_frames == BLINK_FRAMES) begin
          m_frames = 0;
          m_phase  = ~m_phase;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [NUM-1:0] er, ecm;
    for (int i = 0; i < NUM; i++) begin
      er[i]  = reset ? !m_pend[i] : 1'b1;
      ecm[i] = reset ? m_cm[i] : 1'b0;
    end
    check("upd_ready", 32'(upd_ready), 32'(er));
    check("commit_mask", 32'(commit_mask), 32'(ecm));
    if (!reset) check("pixel_in_reset", 32'(pixel), 32'd0);
    else if (exp_q.size() > 0) check("pixel", 32'(pixel), 32'(exp_q.pop_front()));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    upd_valid   = '0;
    frame_start = 1'b0;
  endtask

  task automatic post(int s, int x, int y, int c, bit en, bit bl);
    upd_x[11*s +: 11]    = 11'(x);
    upd_y[10*s +: 10]    = 10'(y);
    upd_color[8*s +: 8]  = 8'(c);
    upd_en[s]            = en;
    upd_blink[s]         = bl;
    upd_valid[s]         = 1'b1;
  endtask

  task automatic fs();
    frame_start = 1'b1;
    cyc();
  endtask

  task automatic scan(int h0, int h1, int v0, int v1);
    for (int v = v0; v <= v1; v++) begin
      for (int h = h0; h <= h1; h++) begin
        hcount = 11'(h);
        vcount = 10'(v);
        cyc();
      end
    end
  endtask

  function automatic int rand_x();
    case ($urandom_range(2, 0))
      0:       return 2040 + $urandom_range(7, 0);
      1:       return 96 + $urandom_range(24, 0);
      default: return $urandom_range(4, 0);
    endcase
  endfunction

  function automatic int rand_y();
    return $urandom_range(1, 0) ? 1016 + $urandom_range(7, 0) : 48 + $urandom_range(16, 0);
  endfunction

  task automatic random_phase(int n);
    for (int k = 0; k < n; k++) begin
      for (int s = 0; s < NUM; s++)
        if ($urandom_range(3, 0) == 0)
          post(s, rand_x(), rand_y(), $urandom_range(255, 1), $urandom_range(7, 0) != 0,
               $urandom_range(1, 0) == 1);
      hcount = 11'(rand_x() + $urandom_range(10, 0) - 3);
      vcount = 10'(rand_y() + $urandom_range(10, 0) - 3);
      frame_start = ($urandom_range(15, 0) == 0);
      cyc();
    end
  endtask

  initial begin
    #23 reset = 1'b1;
    #4;
    cyc();
    // Single marker, full box scan including the border.
    post(0, 100, 50, 8'hFF, 1, 0);
    cyc();
    fs();
    scan(98, 109, 48, 59);
    fs();
    // Overlap: lower index wins.
    post(0, 100, 50, 8'h11, 1, 0);
    post(2, 104, 54, 8'h33, 1, 0);
    cyc();
    fs();
    scan(105, 105, 55, 55);
    scan(110, 110, 60, 60);
    // Request on the frame_start cycle commits one frame later.
    post(1, 300, 200, 8'h44, 1, 0);
    fs();
    scan(299, 302, 200, 201);
    fs();
    scan(299, 302, 200, 201);
    // Second update while pending is refused.
    post(3, 400, 100, 8'h55, 1, 0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      post(3, 500, 100, 8'h66, 1, 0);
      cyc();
    end
    fs();
    scan(399, 401, 100, 100);
    scan(499, 501, 100, 100);
    // Right/bottom edge clip without wrap.
    post(0, 2044, 1020, 8'h77, 1, 0);
    cyc();
    fs();
    scan(2040, 2047, 1019, 1023);
    scan(0, 5, 1019, 1023);
    scan(0, 5, 0, 3);
    // Hide via en=0.
    post(0, 100, 50, 8'h99, 0, 0);
    cyc();
    fs();
    scan(100, 101, 50, 50);
    random_phase(3000);
    // Asynchronous reset mid-cycle.
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_pixel", 32'(pixel), 32'd0);
    check("async_ready", 32'(upd_ready), 32'({NUM{1'b1}}));
    check("async_commit", 32'(commit_mask), 32'd0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    cyc();
    random_phase(1000);
    cyc();
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
